// File: rtl/hamming_decoder.sv
// -----------------------------------------------------------------------------
// hamming_decoder
//
// Hamming(7,4) single-error-correcting decoder with a two-stage registered
// pipeline and saturating statistics counters for bit-error-rate measurement.
//
// Codeword layout on i_data: [3:0] data d3..d0, [4] p0, [5] p1, [6] p2, with
//   p0 = d0^d1^d2, p1 = d1^d2^d3, p2 = d0^d1^d3.
//
// Stage 1 registers the codeword and its syndrome; stage 2 registers the
// corrected data word together with the syndrome and an error flag. A word
// presented with i_dv appears on o_dv exactly two cycles later. There is no
// backpressure, so one word per cycle is accepted and gaps in i_dv reappear
// unchanged on o_dv.
//
// Double-bit errors are not detected: they produce a nonzero syndrome and
// are miscorrected according to the syndrome map, with o_err=1.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_data[6:0] received codeword
//   i_dv        i_data valid this cycle
//   i_clr       synchronous clear of both statistics counters
//   o_data[3:0] corrected data word (qualified by o_dv)
//   o_dv        output word valid
//   o_err       nonzero syndrome on this word (qualified by o_dv)
//   o_syndrome  syndrome {s2,s1,s0} (qualified by o_dv)
//   o_word_cnt  words decoded since reset/clear, saturating
//   o_err_cnt   words with nonzero syndrome since reset/clear, saturating
// -----------------------------------------------------------------------------
module hamming_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [6:0]       i_data,
    input  logic             i_dv,
    input  logic             i_clr,
    output logic [3:0]       o_data,
    output logic             o_dv,
    output logic             o_err,
    output logic [2:0]       o_syndrome,
    output logic [CNT_W-1:0] o_word_cnt,
    output logic [CNT_W-1:0] o_err_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Stage 1 registers
    logic [6:0]       cw_q;
    logic [2:0]       syn1_q;
    logic             v1_q;
    logic [2:0]       syn1_d;

    // Stage 2 registers
    logic [3:0]       data_q;
    logic [2:0]       syn2_q;
    logic             err_q;
    logic             dv_q;
    logic [3:0]       data_d;
    logic [3:0]       flip_mask;

    // Statistics counters
    logic [CNT_W-1:0] word_cnt_q;
    logic [CNT_W-1:0] word_cnt_d;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] err_cnt_d;

    // Syndrome of the incoming codeword: each bit re-checks one parity group.
    always_comb begin
        syn1_d = {i_data[6] ^ i_data[0] ^ i_data[1] ^ i_data[3],
                  i_data[5] ^ i_data[1] ^ i_data[2] ^ i_data[3],
                  i_data[4] ^ i_data[0] ^ i_data[1] ^ i_data[2]};
    end

    // Syndrome-to-data-bit map. Single-hot syndromes point at a parity bit,
    // so the data nibble passes through untouched in those cases.
    always_comb begin
        flip_mask = 4'b0000;
        case (syn1_q)
            3'b101:  flip_mask = 4'b0001;
            3'b111:  flip_mask = 4'b0010;
            3'b011:  flip_mask = 4'b0100;
            3'b110:  flip_mask = 4'b1000;
            default: flip_mask = 4'b0000;
        endcase
        data_d = cw_q[3:0] ^ flip_mask;
    end

    // Pipeline. Data registers load only when a valid word advances so the
    // outputs stay stable across gaps.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cw_q   <= '0;
            syn1_q <= '0;
            v1_q   <= 1'b0;
            data_q <= '0;
            syn2_q <= '0;
            err_q  <= 1'b0;
            dv_q   <= 1'b0;
        end else begin
            v1_q <= i_dv;
            if (i_dv) begin
                cw_q   <= i_data;
                syn1_q <= syn1_d;
            end
            dv_q <= v1_q;
            if (v1_q) begin
                data_q <= data_d;
                syn2_q <= syn1_q;
                err_q  <= |syn1_q;
            end
        end
    end

    // Counters advance on each output word; clear wins over the increment
    // of the same cycle, so that word goes uncounted.
    always_comb begin
        word_cnt_d = word_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (i_clr) begin
            word_cnt_d = '0;
            err_cnt_d  = '0;
        end else if (dv_q) begin
            if (!(&word_cnt_q)) begin
                word_cnt_d = word_cnt_q + CNT_ONE;
            end
            if (err_q && !(&err_cnt_q)) begin
                err_cnt_d = err_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign o_data     = data_q;
    assign o_dv       = dv_q;
    assign o_err      = err_q;
    assign o_syndrome = syn2_q;
    assign o_word_cnt = word_cnt_q;
    assign o_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_hamming_decoder.sv
// -----------------------------------------------------------------------------
// tb_hamming_decoder
//
// Drives directed codewords into two decoder instances (CNT_W=16 and CNT_W=2)
// sharing the same inputs. Each issued word pushes its expected
// {data, err, syndrome} into exp_q; a negedge monitor pops and compares when
// o_dv is high and checks the o_dv pattern against i_dv delayed by two cycles.
// -----------------------------------------------------------------------------
module tb_hamming_decoder;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [6:0]  i_data;
    logic        i_dv;
    logic        i_clr;

    logic [3:0]  o_data;
    logic        o_dv;
    logic        o_err;
    logic [2:0]  o_syndrome;
    logic [15:0] o_word_cnt;
    logic [15:0] o_err_cnt;

    logic [3:0]  s_data;
    logic        s_dv;
    logic        s_err;
    logic [2:0]  s_syndrome;
    logic [1:0]  s_word_cnt;
    logic [1:0]  s_err_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];   // {data[3:0], err, syndrome[2:0]}
    logic [1:0] dv_hist;

    always #5 i_clk = ~i_clk;

    hamming_decoder #(.CNT_W(16)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_data     (i_data),
        .i_dv       (i_dv),
        .i_clr      (i_clr),
        .o_data     (o_data),
        .o_dv       (o_dv),
        .o_err      (o_err),
        .o_syndrome (o_syndrome),
        .o_word_cnt (o_word_cnt),
        .o_err_cnt  (o_err_cnt)
    );

    hamming_decoder #(.CNT_W(2)) dut_s (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_data     (i_data),
        .i_dv       (i_dv),
        .i_clr      (i_clr),
        .o_data     (s_data),
        .o_dv       (s_dv),
        .o_err      (s_err),
        .o_syndrome (s_syndrome),
        .o_word_cnt (s_word_cnt),
        .o_err_cnt  (s_err_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] encode(input logic [3:0] d);
        encode = {d[0] ^ d[1] ^ d[3], d[1] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[2], d};
    endfunction

    // Syndrome produced by a single flip of codeword bit b.
    function automatic logic [2:0] pos_syn(input int b);
        case (b)
            0:       pos_syn = 3'b101;
            1:       pos_syn = 3'b111;
            2:       pos_syn = 3'b011;
            3:       pos_syn = 3'b110;
            4:       pos_syn = 3'b001;
            5:       pos_syn = 3'b010;
            default: pos_syn = 3'b100;
        endcase
    endfunction

    task automatic drive(input logic [6:0] c, input logic v, input logic clr,
                         input logic [3:0] ed, input logic [2:0] es);
        @(posedge i_clk);
        #1;
        i_data = c;
        i_dv   = v;
        i_clr  = clr;
        if (v) exp_q.push_back({ed, (es != 3'b000), es});
    endtask

    task automatic idle(input int n);
        repeat (n) drive(7'h00, 1'b0, 1'b0, 4'h0, 3'b000);
    endtask

    task automatic check_cnt(input string name, input logic [15:0] w, input logic [15:0] e,
                             input logic [1:0] sw, input logic [1:0] se);
        check({name, "_word_cnt"}, o_word_cnt, w);
        check({name, "_err_cnt"}, o_err_cnt, e);
        check({name, "_sat_word_cnt"}, s_word_cnt, sw);
        check({name, "_sat_err_cnt"}, s_err_cnt, se);
    endtask

    // Reference for output timing: i_dv delayed two cycles, dropped by reset.
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) dv_hist <= 2'b00;
        else          dv_hist <= {dv_hist[0], i_dv};
    end

    // Monitor
    always @(negedge i_clk) begin
        logic [7:0] e;
        if (i_rst_n) begin
            check("o_dv_timing", o_dv, dv_hist[1]);
            if (o_dv) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%0h expected=none", o_data);
                end else begin
                    e = exp_q.pop_front();
                    check("o_data", o_data, e[7:4]);
                    check("o_err", o_err, e[3]);
                    check("o_syndrome", o_syndrome, e[2:0]);
                    check("sat_o_data", s_data, e[7:4]);
                end
            end
        end
    end

    initial begin
        logic [6:0] code;
        logic [2:0] es;
        int         b;
        int         n;

        i_rst_n = 1'b0;
        i_dv    = 1'b0;
        i_data  = 7'h00;
        i_clr   = 1'b0;
        #12;
        check("rst_o_dv", o_dv, 0);
        check("rst_o_data", o_data, 0);
        check("rst_o_err", o_err, 0);
        check("rst_o_syndrome", o_syndrome, 0);
        check_cnt("rst", 16'd0, 16'd0, 2'd0, 2'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Clean word
        drive(7'h4B, 1'b1, 1'b0, 4'hB, 3'b000);
        idle(4);
        check_cnt("clean", 16'd1, 16'd0, 2'd1, 2'd0);

        // Single data-bit errors
        drive(7'h4F, 1'b1, 1'b0, 4'hB, 3'b011);
        drive(7'h4A, 1'b1, 1'b0, 4'hB, 3'b101);
        drive(7'h49, 1'b1, 1'b0, 4'hB, 3'b111);
        drive(7'h43, 1'b1, 1'b0, 4'hB, 3'b110);
        idle(4);
        check_cnt("data_err", 16'd5, 16'd4, 2'd3, 2'd3);

        // Single parity-bit errors
        drive(7'h5B, 1'b1, 1'b0, 4'hB, 3'b001);
        drive(7'h6B, 1'b1, 1'b0, 4'hB, 3'b010);
        drive(7'h0B, 1'b1, 1'b0, 4'hB, 3'b100);
        idle(4);
        check_cnt("par_err", 16'd8, 16'd7, 2'd3, 2'd3);

        // Plain clear
        drive(7'h00, 1'b0, 1'b1, 4'h0, 3'b000);
        idle(1);
        check_cnt("clr", 16'd0, 16'd0, 2'd0, 2'd0);

        // Clear in the same cycle as an output word: word not counted
        drive(7'h4F, 1'b1, 1'b0, 4'hB, 3'b011);
        idle(1);
        drive(7'h00, 1'b0, 1'b1, 4'h0, 3'b000);
        idle(1);
        check_cnt("clr_same", 16'd0, 16'd0, 2'd0, 2'd0);
        idle(3);
        check("hold_o_data", o_data, 4'hB);
        check("hold_o_err", o_err, 1);
        check("hold_o_syndrome", o_syndrome, 3'b011);

        // Streaming: all 16 values back to back, one random flip on odd words
        for (int d = 0; d < 16; d++) begin
            code = encode(d[3:0]);
            es   = 3'b000;
            if (d % 2 == 1) begin
                b    = $urandom_range(0, 6);
                code = code ^ (7'h01 << b);
                es   = pos_syn(b);
            end
            drive(code, 1'b1, 1'b0, d[3:0], es);
        end
        idle(4);
        check_cnt("stream", 16'd16, 16'd8, 2'd3, 2'd3);

        // Gap pattern 1,0,1,1,0
        drive(encode(4'h3), 1'b1, 1'b0, 4'h3, 3'b000);
        idle(1);
        drive(encode(4'h5) ^ 7'h40, 1'b1, 1'b0, 4'h5, 3'b100);
        drive(encode(4'h9), 1'b1, 1'b0, 4'h9, 3'b000);
        idle(5);
        check_cnt("gap", 16'd19, 16'd9, 2'd3, 2'd3);

        // Reset mid-stream, asserted between edges
        drive(encode(4'h1), 1'b1, 1'b0, 4'h1, 3'b000);
        drive(encode(4'h2), 1'b1, 1'b0, 4'h2, 3'b000);
        drive(encode(4'h4), 1'b1, 1'b0, 4'h4, 3'b000);
        drive(encode(4'h6), 1'b1, 1'b0, 4'h6, 3'b000);
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        i_dv    = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_o_dv", o_dv, 0);
        check("midrst_o_data", o_data, 0);
        check("midrst_o_err", o_err, 0);
        check("midrst_o_syndrome", o_syndrome, 0);
        check_cnt("midrst", 16'd0, 16'd0, 2'd0, 2'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        idle(2);

        // First word after reset: bounded latency measurement
        @(posedge i_clk);
        #1;
        i_data = 7'h4A;
        i_dv   = 1'b1;
        exp_q.push_back({4'hB, 1'b1, 3'b101});
        n = 0;
        while (n < 8) begin
            @(posedge i_clk);
            #1;
            if (n == 0) i_dv = 1'b0;
            n++;
            if (o_dv) break;
        end
        check("post_rst_latency", n, 2);
        idle(3);
        check_cnt("post_rst", 16'd1, 16'd1, 2'd1, 2'd1);
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
